// File: rtl/ycr_wb_arb_pkg.sv
// Shared types and constants for the Wishbone burst arbiter.
// Burst length 0 on the bus encodes a 256-beat burst.
package ycr_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int WB_BL_W       = 8;
    localparam int BL_ZERO_BEATS = 256;

    function automatic logic [8:0] bl_beats(input logic [WB_BL_W-1:0] bl);
        return (bl == '0) ? 9'(BL_ZERO_BEATS) : {1'b0, bl};
    endfunction

endpackage

// File: rtl/ycr_wb_burst_arb_if.sv
// Master-side and slave-side Wishbone burst signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface ycr_wb_burst_arb_if
    import ycr_wb_arb_pkg::*;
#(
    parameter int NUM_MST  = 2,
    parameter int WB_WIDTH = 32
);
    logic [NUM_MST-1:0]          m_stb_i;
    logic [NUM_MST*WB_WIDTH-1:0] m_adr_i;
    logic [NUM_MST-1:0]          m_we_i;
    logic [NUM_MST*WB_WIDTH-1:0] m_dat_i;
    logic [NUM_MST*4-1:0]        m_sel_i;
    logic [NUM_MST*WB_BL_W-1:0]  m_bl_i;
    logic [WB_WIDTH-1:0]         m_dat_o;
    logic [NUM_MST-1:0]          m_ack_o;
    logic [NUM_MST-1:0]          m_lack_o;
    logic [NUM_MST-1:0]          m_err_o;

    logic                        s_stb_o;
    logic [WB_WIDTH-1:0]         s_adr_o;
    logic                        s_we_o;
    logic [WB_WIDTH-1:0]         s_dat_o;
    logic [3:0]                  s_sel_o;
    logic [WB_BL_W-1:0]          s_bl_o;
    logic [WB_WIDTH-1:0]         s_dat_i;
    logic                        s_ack_i;
    logic                        s_lack_i;
    logic                        s_err_i;

    modport slave (
        input  m_stb_i, m_adr_i, m_we_i, m_dat_i, m_sel_i, m_bl_i,
        input  s_dat_i, s_ack_i, s_lack_i, s_err_i,
        output m_dat_o, m_ack_o, m_lack_o, m_err_o,
        output s_stb_o, s_adr_o, s_we_o, s_dat_o, s_sel_o, s_bl_o
    );

    modport master (
        output m_stb_i, m_adr_i, m_we_i, m_dat_i, m_sel_i, m_bl_i,
        output s_dat_i, s_ack_i, s_lack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_lack_o, m_err_o,
        input  s_stb_o, s_adr_o, s_we_o, s_dat_o, s_sel_o, s_bl_o
    );

endinterface

// File: rtl/ycr_rr_pick.sv
// Combinational round-robin picker: first requester after last_i,
// wrapping modulo NUM_MST.
module ycr_rr_pick #(
    parameter  int NUM_MST = 2,
    localparam int IW      = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic               valid_o,
    output logic [IW-1:0]      idx_o
);

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = last_i;
        cand    = last_i;
        for (int k = NUM_MST; k >= 1; k--) begin
            cand = IW'((int'(last_i) + k) % NUM_MST);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/ycr_wb_burst_arb.sv
// Round-robin Wishbone burst arbiter: one burst slave shared by NUM_MST masters.
// Grant is held for a whole burst and always followed by one stb-low GAP cycle.
module ycr_wb_burst_arb
    import ycr_wb_arb_pkg::*;
#(
    parameter int NUM_MST  = 2,
    parameter int WB_WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    ycr_wb_burst_arb_if.slave bus
);

    localparam int IW = $clog2(NUM_MST);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]       last_idx_q, last_idx_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;

    logic                pick_vld;
    logic [IW-1:0]       pick_idx;
    logic                gnt_stb;
    logic [WB_WIDTH-1:0] gnt_adr;
    logic [WB_WIDTH-1:0] gnt_dat;
    logic [3:0]          gnt_sel;
    logic [WB_BL_W-1:0]  gnt_bl;
    logic                last_beat;
    logic                rel;

    ycr_rr_pick #(.NUM_MST(NUM_MST)) u_pick (
        .req_i   (bus.m_stb_i),
        .last_i  (last_idx_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    assign gnt_stb = bus.m_stb_i[gnt_idx_q];
    assign gnt_adr = bus.m_adr_i[int'(gnt_idx_q)*WB_WIDTH +: WB_WIDTH];
    assign gnt_dat = bus.m_dat_i[int'(gnt_idx_q)*WB_WIDTH +: WB_WIDTH];
    assign gnt_sel = bus.m_sel_i[int'(gnt_idx_q)*4 +: 4];
    assign gnt_bl  = bus.m_bl_i[int'(gnt_idx_q)*WB_BL_W +: WB_BL_W];

    // Beat counter is a safety net for slaves that never raise lack.
    assign last_beat = bus.s_ack_i
                     & ((beat_cnt_q + 9'd1) == bl_beats(gnt_bl));
    assign rel = (bus.s_ack_i & bus.s_lack_i) | bus.s_err_i
               | last_beat | ~gnt_stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IW'(NUM_MST - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d    = BUSY;
                    gnt_idx_d  = pick_idx;
                    last_idx_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                if (bus.s_ack_i) beat_cnt_d = beat_cnt_q + 9'd1;
                if (rel) state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address/data mux stays live outside BUSY but is forced low in reset.
    always_comb begin
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_sel_o  = '0;
        bus.s_bl_o   = '0;
        bus.s_adr_o  = rst_n ? gnt_adr : '0;
        bus.s_dat_o  = rst_n ? gnt_dat : '0;
        bus.m_dat_o  = bus.s_dat_i;
        bus.m_ack_o  = '0;
        bus.m_lack_o = '0;
        bus.m_err_o  = '0;
        if (state_q == BUSY) begin
            bus.s_stb_o             = gnt_stb;
            bus.s_we_o              = bus.m_we_i[gnt_idx_q];
            bus.s_sel_o             = gnt_sel;
            bus.s_bl_o              = gnt_bl;
            bus.m_ack_o[gnt_idx_q]  = bus.s_ack_i;
            bus.m_lack_o[gnt_idx_q] = bus.s_lack_i;
            bus.m_err_o[gnt_idx_q]  = bus.s_err_i;
        end
    end

endmodule

// File: tb/tb_ycr_wb_burst_arb.sv
// Bench for ycr_wb_burst_arb: master/slave models plus a burst scoreboard
// keyed on the granted master's address, ack count and stb-low gap.
module tb_ycr_wb_burst_arb;

    localparam int N = 2;
    localparam int W = 32;

    typedef struct {
        int mst;
        int acks;
        int gap;
    } exp_t;

    logic clk;
    logic rst_n;

    ycr_wb_burst_arb_if #(.NUM_MST(N), .WB_WIDTH(W)) bus ();

    ycr_wb_burst_arb #(.NUM_MST(N), .WB_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t e;

    int   mst_bursts[N];
    int   mst_acks[N];
    int   mst_bl[N];
    logic mst_we[N];

    int   slv_cnt      = 0;
    logic slv_no_lack  = 1'b0;
    logic slv_force    = 1'b0;
    int   slv_err_beat = 0;
    int   s_beats;

    logic         sn_stb  = 1'b0;
    logic         sn_sack = 1'b0;
    logic [N-1:0] sn_ack  = '0;
    logic [N-1:0] sn_lack = '0;
    logic [N-1:0] sn_err  = '0;
    logic         sn_we   = 1'b0;
    logic [3:0]   sn_sel  = '0;
    logic [7:0]   sn_bl   = '0;
    logic [W-1:0] sn_dat  = '0;

    logic         in_burst = 1'b0;
    logic [W-1:0] cur_adr;
    int           cur_acks;
    int           cur_bad;
    int           cur_gap;
    int           gap_len  = 99;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave: acks every strobed cycle, lack on the last beat of s_bl_o.
    assign s_beats       = (bus.s_bl_o == 8'd0) ? 256 : int'(bus.s_bl_o);
    assign bus.s_ack_i   = bus.s_stb_o | slv_force;
    assign bus.s_lack_i  = bus.s_ack_i & ~slv_no_lack
                         & ((slv_cnt + 1) == s_beats);
    assign bus.s_err_i   = bus.s_ack_i & (slv_err_beat != 0)
                         & ((slv_cnt + 1) == slv_err_beat);
    assign bus.s_dat_i   = W'(32'hD000_0000 + slv_cnt);

    function automatic int beats(input int bl);
        return (bl == 0) ? 256 : bl;
    endfunction

    function automatic logic any_req();
        logic r = 1'b0;
        for (int i = 0; i < N; i++) if (mst_bursts[i] > 0) r = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.m_stb_i[i]           = (mst_bursts[i] > 0);
            bus.m_we_i[i]            = mst_we[i];
            bus.m_bl_i[i*8 +: 8]     = 8'(mst_bl[i]);
            bus.m_adr_i[i*W +: W]    = W'(32'h1000 * (i + 1));
            bus.m_dat_i[i*W +: W]    = W'(32'hA000_0000 + i);
            bus.m_sel_i[i*4 +: 4]    = (i == 0) ? 4'h5 : 4'hA;
        end
    endtask

    // Sample the cycle at negedge, then update the models after the edge.
    task automatic tick();
        @(negedge clk);
        sn_stb  = bus.s_stb_o;
        sn_sack = bus.s_ack_i;
        sn_ack  = bus.m_ack_o;
        sn_lack = bus.m_lack_o;
        sn_err  = bus.m_err_o;
        sn_we   = bus.s_we_o;
        sn_sel  = bus.s_sel_o;
        sn_bl   = bus.s_bl_o;
        sn_dat  = bus.m_dat_o;
        @(posedge clk);
        #1;
        if (!sn_stb) slv_cnt = 0;
        else if (sn_sack) slv_cnt++;
        for (int i = 0; i < N; i++) begin
            if (sn_ack[i]) begin
                mst_acks[i]++;
                if (sn_lack[i] || sn_err[i]
                    || mst_acks[i] == beats(mst_bl[i])) begin
                    mst_acks[i] = 0;
                    if (mst_bursts[i] > 0) mst_bursts[i]--;
                end
            end
        end
        drive();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((any_req() || sn_stb) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
        tick();
        tick();
    endtask

    // Scoreboard: one entry per burst, closed when stb falls.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_burst = 1'b0;
            gap_len  = 99;
        end else if (bus.s_stb_o) begin
            if (!in_burst) begin
                in_burst = 1'b1;
                cur_adr  = bus.s_adr_o;
                cur_acks = 0;
                cur_bad  = 0;
                cur_gap  = gap_len;
            end
            if (sb.size() > 0) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.m_ack_o[i]) begin
                        if (i == sb[0].mst) cur_acks++;
                        else cur_bad++;
                    end
                end
            end
        end else if (in_burst) begin
            in_burst = 1'b0;
            gap_len  = 1;
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("burst_master_adr", 64'(cur_adr),
                    64'(32'h1000 * (e.mst + 1)));
                chk("burst_acks", 64'(cur_acks), 64'(e.acks));
                chk("burst_stray_acks", 64'(cur_bad), 64'd0);
                if (e.gap != 0) chk("burst_gap", 64'(cur_gap), 64'(e.gap));
            end
        end else begin
            gap_len++;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            mst_bursts[i] = 0;
            mst_acks[i]   = 0;
            mst_bl[i]     = 4;
            mst_we[i]     = 1'b0;
        end
        drive();
        tick();
        tick();
        chk("rst_s_stb", 64'(bus.s_stb_o), 64'd0);
        chk("rst_s_adr", 64'(bus.s_adr_o), 64'd0);
        chk("rst_s_we", 64'(bus.s_we_o), 64'd0);
        chk("rst_s_sel", 64'(bus.s_sel_o), 64'd0);
        chk("rst_s_bl", 64'(bus.s_bl_o), 64'd0);
        chk("rst_m_ack", 64'(bus.m_ack_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single master 0 read, bl=4.
        mst_bl[0] = 4;
        mst_bursts[0] = 1;
        sb.push_back('{mst: 0, acks: 4, gap: 0});
        drive();
        tick();
        chk("t1_idle_stb", 64'(sn_stb), 64'd0);
        tick();
        chk("t1_grant_stb", 64'(sn_stb), 64'd1);
        chk("t1_grant_bl", 64'(sn_bl), 64'd4);
        n = 0;
        while (!sn_lack[0] && n < 20) begin
            tick();
            n++;
        end
        chk("t1_lack_beat", 64'(n), 64'd3);
        chk("t1_lack_dat", 64'(sn_dat), 64'(32'hD000_0003));
        slv_force = 1'b1;
        tick();
        chk("t1_gap_ack_drop", 64'(sn_ack), 64'd0);
        chk("t1_gap_stb", 64'(sn_stb), 64'd0);
        slv_force = 1'b0;
        tick();
        chk("t1_idle_stb2", 64'(sn_stb), 64'd0);
        wait_done("t1", 30);

        // Two masters continuous from reset: 0,1,0,1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mst_bl[0] = 8;
        mst_bl[1] = 8;
        mst_bursts[0] = 2;
        mst_bursts[1] = 2;
        sb.push_back('{mst: 0, acks: 8, gap: 0});
        sb.push_back('{mst: 1, acks: 8, gap: 2});
        sb.push_back('{mst: 0, acks: 8, gap: 2});
        sb.push_back('{mst: 1, acks: 8, gap: 2});
        drive();
        wait_done("t2", 80);

        // Master 1 aborts after beat 2 while master 0 waits.
        mst_bl[1] = 8;
        mst_bursts[1] = 1;
        sb.push_back('{mst: 1, acks: 2, gap: 0});
        sb.push_back('{mst: 0, acks: 4, gap: 3});
        drive();
        n = 0;
        while (!sn_stb && n < 10) begin
            tick();
            n++;
        end
        mst_bl[0] = 4;
        mst_bursts[0] = 1;
        drive();
        n = 0;
        while (mst_acks[1] != 2 && n < 20) begin
            tick();
            n++;
        end
        chk("t3_beat2_seen", 64'(mst_acks[1]), 64'd2);
        mst_bursts[1] = 0;
        mst_acks[1] = 0;
        drive();
        wait_done("t3", 40);

        // Slave error on beat 3 of a write bl=4.
        mst_bl[0] = 4;
        mst_we[0] = 1'b1;
        mst_bursts[0] = 2;
        slv_err_beat = 3;
        sb.push_back('{mst: 0, acks: 3, gap: 0});
        sb.push_back('{mst: 0, acks: 3, gap: 2});
        drive();
        n = 0;
        while (sn_err == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_err_vec", 64'(sn_err), 64'd1);
        chk("t4_we", 64'(sn_we), 64'd1);
        chk("t4_sel", 64'(sn_sel), 64'h5);
        wait_done("t4", 40);
        slv_err_beat = 0;
        mst_we[0] = 1'b0;
        drive();

        // Missing lack: beat counter releases bl=2 and bl=0 (256).
        slv_no_lack = 1'b1;
        mst_bl[1] = 2;
        mst_bursts[1] = 2;
        sb.push_back('{mst: 1, acks: 2, gap: 0});
        sb.push_back('{mst: 1, acks: 2, gap: 2});
        drive();
        wait_done("t5a", 40);
        mst_bl[0] = 0;
        mst_bursts[0] = 2;
        sb.push_back('{mst: 0, acks: 256, gap: 0});
        sb.push_back('{mst: 0, acks: 256, gap: 2});
        drive();
        wait_done("t5b", 700);
        slv_no_lack = 1'b0;

        // Reset during beat 3 of 8, then master 0 wins first.
        mst_bl[1] = 8;
        mst_bursts[1] = 1;
        drive();
        n = 0;
        while (mst_acks[1] != 2 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_beat2_seen", 64'(mst_acks[1]), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_s_stb", 64'(bus.s_stb_o), 64'd0);
        chk("t6_rst_m_ack", 64'(bus.m_ack_o), 64'd0);
        chk("t6_rst_m_lack", 64'(bus.m_lack_o), 64'd0);
        chk("t6_rst_s_bl", 64'(bus.s_bl_o), 64'd0);
        for (int i = 0; i < N; i++) mst_acks[i] = 0;
        mst_bl[0] = 4;
        mst_bursts[0] = 1;
        mst_bursts[1] = 1;
        sb.push_back('{mst: 0, acks: 4, gap: 0});
        sb.push_back('{mst: 1, acks: 8, gap: 2});
        drive();
        tick();
        tick();
        rst_n = 1'b1;
        wait_done("t6", 40);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
